// File: rtl/ysyx_040729_clint_pkg.sv
// Shared types, address map constants and helpers for the CLINT port arbiter.
package ysyx_040729_clint_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } arb_state_e;

  // CLINT register map: upper address bits and the two mapped word offsets.
  localparam logic [47:0] CLINT_BASE   = 48'h200;
  localparam logic [15:0] MTIME_OFF    = 16'hbff8;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;

  // Widest data path the mask helper supports; narrower builds slice the result.
  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  // Expand each byte-enable bit into a full byte of mask.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_mask(
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(MAX_STRB_WIDTH); i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_040729_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req[1:0]   request vector (bit 0 = m0, bit 1 = m1)
//   advance    a grant was consumed this cycle; move the pointer
//   gnt[1:0]   one-hot grant (all zero when nothing requests)
module ysyx_040729_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: m0 preferred, 1: m1 preferred.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    // After granting m0 prefer m1 next, and vice versa.
    if (advance) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ysyx_040729_clint_arb.sv
// Shares the single CLINT register port between the core LSU (m0) and a debug/DMA
// master (m1). One transaction in flight, round-robin between the two requesters.
// Byte-strobed writes become full-word CLINT writes via read-modify-write.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   mN_req_*              request channel (valid/ready, addr, wen, wdata, wstrb)
//   mN_resp_*             response channel (valid/ready, rdata, err)
//   clint_addr/wdata/wen  CLINT register port; clint_wen is a one-cycle pulse
//   clint_rdata           combinational CLINT read data
// Configuration:
//   CLINT_ARB_DECERR_EN   when defined, unmapped addresses skip the CLINT and return
//                         resp_err = 1; otherwise every access goes to the CLINT.
module ysyx_040729_clint_arb
  import ysyx_040729_clint_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [DATA_WIDTH-1:0] m0_req_addr,
  input  logic                  m0_req_wen,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic [STRB_WIDTH-1:0] m0_req_wstrb,
  output logic                  m0_resp_valid,
  input  logic                  m0_resp_ready,
  output logic [DATA_WIDTH-1:0] m0_resp_rdata,
  output logic                  m0_resp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [DATA_WIDTH-1:0] m1_req_addr,
  input  logic                  m1_req_wen,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  input  logic [STRB_WIDTH-1:0] m1_req_wstrb,
  output logic                  m1_resp_valid,
  input  logic                  m1_resp_ready,
  output logic [DATA_WIDTH-1:0] m1_resp_rdata,
  output logic                  m1_resp_err,
  output logic [DATA_WIDTH-1:0] clint_addr,
  output logic [DATA_WIDTH-1:0] clint_wdata,
  output logic                  clint_wen,
  input  logic [DATA_WIDTH-1:0] clint_rdata
);

  arb_state_e            state_q, state_d;
  logic                  id_q, id_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [1:0]                gnt;
  logic                      accept;
  logic [DATA_WIDTH-1:0]     sel_addr, sel_wdata;
  logic                      sel_wen;
  logic [STRB_WIDTH-1:0]     sel_wstrb;
  arb_state_e                acc_state;
  logic [MAX_DATA_WIDTH-1:0] mask_full;
  logic [DATA_WIDTH-1:0]     mask, merged;
  logic                      resp_ready_sel;

  ysyx_040729_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req_valid, m0_req_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign m0_req_ready = (state_q == StIdle) & gnt[0] & ~rst;
  assign m1_req_ready = (state_q == StIdle) & gnt[1] & ~rst;
  assign accept       = m0_req_ready | m1_req_ready;

  assign sel_addr  = gnt[1] ? m1_req_addr  : m0_req_addr;
  assign sel_wen   = gnt[1] ? m1_req_wen   : m0_req_wen;
  assign sel_wdata = gnt[1] ? m1_req_wdata : m0_req_wdata;
  assign sel_wstrb = gnt[1] ? m1_req_wstrb : m0_req_wstrb;

  assign mask_full = strb_to_mask(MAX_STRB_WIDTH'(wstrb_q));
  assign mask      = mask_full[DATA_WIDTH-1:0];
  // A concurrent mtime increment between RD and WR is deliberately overwritten here.
  assign merged    = (clint_rdata & ~mask) | (wdata_q & mask);

  assign resp_ready_sel = id_q ? m1_resp_ready : m0_resp_ready;

`ifdef CLINT_ARB_DECERR_EN
  logic dec_hit;
  // Bits [2:0] select a byte within the word and take no part in the decode.
  assign dec_hit = (sel_addr[DATA_WIDTH-1:16] == (DATA_WIDTH-16)'(CLINT_BASE)) &&
                   ((sel_addr[15:3] == MTIMECMP_OFF[15:3]) ||
                    (sel_addr[15:3] == MTIME_OFF[15:3]));
`endif

  // Path taken by a mapped access, chosen from the request being accepted.
  always_comb begin
    acc_state = StRd;
    if (sel_wen) begin
      if (sel_wstrb == '0) begin
        acc_state = StResp;
      end else if (&sel_wstrb) begin
        acc_state = StWr;
      end else begin
        acc_state = StRd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d    = gnt[1];
          addr_d  = sel_addr;
          wen_d   = sel_wen;
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = acc_state;
`ifdef CLINT_ARB_DECERR_EN
          if (!dec_hit) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StRd: begin
        if (wen_q) begin
          wdata_d = merged;
          state_d = StWr;
        end else begin
          rdata_d = clint_rdata;
          state_d = StResp;
        end
      end
      StWr: begin
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready_sel) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign clint_addr  = addr_q;
  assign clint_wdata = wdata_q;
  // Gated by rst so a reset landing in WR suppresses the write.
  assign clint_wen   = (state_q == StWr) & ~rst;

  assign m0_resp_valid = (state_q == StResp) & ~id_q;
  assign m1_resp_valid = (state_q == StResp) & id_q;
  assign m0_resp_rdata = m0_resp_valid ? rdata_q : '0;
  assign m1_resp_rdata = m1_resp_valid ? rdata_q : '0;
  assign m0_resp_err   = m0_resp_valid & err_q;
  assign m1_resp_err   = m1_resp_valid & err_q;

endmodule

// File: tb/tb_ysyx_040729_clint_arb.sv
module tb_ysyx_040729_clint_arb;

  localparam logic [63:0] ADDR_CMP   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] ADDR_MTIME = 64'h0000_0000_0200_bff8;
  localparam logic [63:0] ADDR_UNMAP = 64'h0000_0000_0200_0008;
`ifdef CLINT_ARB_DECERR_EN
  localparam logic        UNMAP_ERR = 1'b1;
  localparam int          UNMAP_LAT = 1;
`else
  localparam logic        UNMAP_ERR = 1'b0;
  localparam int          UNMAP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_wen, m0_resp_valid, m0_resp_ready, m0_resp_err;
  logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready, m1_resp_err;
  logic [63:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
  logic [63:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
  logic [7:0]  m0_req_wstrb, m1_req_wstrb;
  logic [63:0] clint_addr, clint_wdata, clint_rdata;
  logic        clint_wen;

  // CLINT model: two registers, bits [2:0] of the address ignored.
  logic [63:0] mtimecmp_m = '0;
  logic [63:0] mtime_m    = '0;
  int          wen_cnt    = 0;
  logic [63:0] last_wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Grant log for the contention scenario.
  logic log_en    = 1'b0;
  logic both_seen = 1'b0;
  int   cyc       = 0;
  int   gid_log[$];
  int   gcyc_log[$];

  always #5 clk = ~clk;

  ysyx_040729_clint_arb dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req_valid  (m0_req_valid),
    .m0_req_ready  (m0_req_ready),
    .m0_req_addr   (m0_req_addr),
    .m0_req_wen    (m0_req_wen),
    .m0_req_wdata  (m0_req_wdata),
    .m0_req_wstrb  (m0_req_wstrb),
    .m0_resp_valid (m0_resp_valid),
    .m0_resp_ready (m0_resp_ready),
    .m0_resp_rdata (m0_resp_rdata),
    .m0_resp_err   (m0_resp_err),
    .m1_req_valid  (m1_req_valid),
    .m1_req_ready  (m1_req_ready),
    .m1_req_addr   (m1_req_addr),
    .m1_req_wen    (m1_req_wen),
    .m1_req_wdata  (m1_req_wdata),
    .m1_req_wstrb  (m1_req_wstrb),
    .m1_resp_valid (m1_resp_valid),
    .m1_resp_ready (m1_resp_ready),
    .m1_resp_rdata (m1_resp_rdata),
    .m1_resp_err   (m1_resp_err),
    .clint_addr    (clint_addr),
    .clint_wdata   (clint_wdata),
    .clint_wen     (clint_wen),
    .clint_rdata   (clint_rdata)
  );

  assign clint_rdata = (clint_addr[63:3] == ADDR_CMP[63:3])   ? mtimecmp_m :
                       (clint_addr[63:3] == ADDR_MTIME[63:3]) ? mtime_m    : 64'h0;

  // Inputs change #1 after posedge, so the negedge sees settled combinational outputs.
  always @(negedge clk) begin
    if (clint_wen) begin
      wen_cnt    <= wen_cnt + 1;
      last_wdata <= clint_wdata;
      if (clint_addr[63:3] == ADDR_CMP[63:3])   mtimecmp_m <= clint_wdata;
      if (clint_addr[63:3] == ADDR_MTIME[63:3]) mtime_m    <= clint_wdata;
    end
    if (m0_req_ready && m1_req_ready) both_seen <= 1'b1;
    if (log_en && m0_req_ready) begin gid_log.push_back(0); gcyc_log.push_back(cyc); end
    if (log_en && m1_req_ready) begin gid_log.push_back(1); gcyc_log.push_back(cyc); end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic req_ready(input int p);
    return (p == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  function automatic logic resp_valid(input int p);
    return (p == 0) ? m0_resp_valid : m1_resp_valid;
  endfunction

  task automatic drive_req(input int p, input logic v, input logic [63:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] s);
    if (p == 0) begin
      m0_req_valid = v; m0_req_addr = a; m0_req_wen = w; m0_req_wdata = d; m0_req_wstrb = s;
    end else begin
      m1_req_valid = v; m1_req_addr = a; m1_req_wen = w; m1_req_wdata = d; m1_req_wstrb = s;
    end
  endtask

  // Starts just after a posedge; returns just after the posedge ending the response.
  task automatic run_txn(input int p, input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] s, output logic [63:0] rd, output logic er,
                         output int lat);
    logic ok;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    drive_req(p, 1'b1, a, w, d, s);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready(p)) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    drive_req(p, 1'b0, '0, 1'b0, '0, '0);
    ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid(p)) begin ok = 1'b1; lat = i; break; end
    end
    if (!ok) check("resp_timeout", 64'(ok), 64'd1);
    rd = (p == 0) ? m0_resp_rdata : m1_resp_rdata;
    er = (p == 0) ? m0_resp_err : m1_resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          wen0;
    logic        ok;

    rst = 1'b1;
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    drive_req(0, 1'b0, '0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state; ready must stay low under reset even with a valid request.
    m0_req_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(m0_req_ready), 64'd0);
    check("rst_resp_valid", 64'(m0_resp_valid | m1_resp_valid), 64'd0);
    check("rst_clint_wen", 64'(clint_wen), 64'd0);
    check("rst_clint_addr", clint_addr, 64'd0);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 64'(m0_req_ready | m1_req_ready), 64'd0);
    @(posedge clk); #1;

    // Full write of mtimecmp, then read it back.
    wen0 = wen_cnt;
    run_txn(0, ADDR_CMP, 1'b1, 64'h1234, 8'hFF, rd, er, lat);
    check("fw_lat", 64'(lat), 64'd2);
    check("fw_rdata", rd, 64'd0);
    check("fw_wen_cnt", 64'(wen_cnt - wen0), 64'd1);
    check("fw_mtimecmp", mtimecmp_m, 64'h1234);

    run_txn(0, ADDR_CMP, 1'b0, '0, '0, rd, er, lat);
    check("rd_lat", 64'(lat), 64'd2);
    check("rd_rdata", rd, 64'h1234);
    check("rd_err", 64'(er), 64'd0);

    // Partial write from m1 merges the low four bytes.
    run_txn(0, ADDR_CMP, 1'b1, 64'h1111_2222_3333_4444, 8'hFF, rd, er, lat);
    check("setup_mtimecmp", mtimecmp_m, 64'h1111_2222_3333_4444);
    wen0 = wen_cnt;
    run_txn(1, ADDR_CMP, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er, lat);
    check("pw_lat", 64'(lat), 64'd3);
    check("pw_wen_cnt", 64'(wen_cnt - wen0), 64'd1);
    check("pw_wdata", last_wdata, 64'h1111_2222_AAAA_AAAA);
    check("pw_rdata", rd, 64'd0);
    check("pw_err", 64'(er), 64'd0);

    // Zero-strobe write: straight to response, nothing written.
    wen0 = wen_cnt;
    run_txn(1, ADDR_CMP, 1'b1, 64'hDEAD_BEEF, 8'h00, rd, er, lat);
    check("zs_lat", 64'(lat), 64'd1);
    check("zs_wen_cnt", 64'(wen_cnt - wen0), 64'd0);
    check("zs_err", 64'(er), 64'd0);
    check("zs_mtimecmp", mtimecmp_m, 64'h1111_2222_AAAA_AAAA);

    // Unmapped read.
    wen0 = wen_cnt;
    run_txn(0, ADDR_UNMAP, 1'b0, '0, '0, rd, er, lat);
    check("um_lat", 64'(lat), 64'(UNMAP_LAT));
    check("um_err", 64'(er), 64'(UNMAP_ERR));
    check("um_rdata", rd, 64'd0);
    check("um_wen_cnt", 64'(wen_cnt - wen0), 64'd0);

    // Back-pressure on m0 while m1 waits.
    m0_resp_ready = 1'b0;
    drive_req(0, 1'b1, ADDR_CMP, 1'b0, '0, '0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("bp_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, 1'b0, '0, '0);
    drive_req(1, 1'b1, ADDR_CMP, 1'b0, '0, '0);
    @(negedge clk);
    check("bp_rd_m1_ready", 64'(m1_req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", 64'(m0_resp_valid), 64'd1);
      check("bp_rdata", m0_resp_rdata, 64'h1111_2222_AAAA_AAAA);
      check("bp_err", 64'(m0_resp_err), 64'd0);
      check("bp_m1_ready", 64'(m1_req_ready), 64'd0);
      check("bp_m1_resp", 64'(m1_resp_valid), 64'd0);
    end
    @(posedge clk); #1;
    m0_resp_ready = 1'b1;
    @(posedge clk); #1;
    // m1 withdraws before it is accepted: no grant, no state change.
    drive_req(1, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("wd_m1_ready", 64'(m1_req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wd_resp", 64'(m0_resp_valid | m1_resp_valid), 64'd0);
    @(posedge clk); #1;

    // Reset landing in WR: m0 full write to mtime is dropped.
    wen0 = wen_cnt;
    drive_req(0, 1'b1, ADDR_MTIME, 1'b1, 64'h5555, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("rw_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rw_clint_wen", 64'(clint_wen), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rw_no_resp", 64'(m0_resp_valid | m1_resp_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("rw_clint_addr", clint_addr, 64'd0);
    check("rw_wen_cnt", 64'(wen_cnt - wen0), 64'd0);
    check("rw_mtime", mtime_m, 64'd0);

    // Contention: both valid continuously; pointer restarted at m0 by the reset.
    log_en = 1'b1;
    drive_req(0, 1'b1, ADDR_CMP, 1'b0, '0, '0);
    drive_req(1, 1'b1, ADDR_CMP, 1'b0, '0, '0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (gid_log.size() >= 4) begin ok = 1'b1; break; end
    end
    if (!ok) check("ct_timeout", 64'(gid_log.size()), 64'd4);
    @(posedge clk); #1;
    log_en = 1'b0;
    drive_req(0, 1'b0, '0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ct_gnt%0d", i), 64'(gid_log[i]), 64'(i % 2));
      end
      for (int i = 1; i < 4; i++) begin
        check($sformatf("ct_gap%0d", i), 64'(gcyc_log[i] - gcyc_log[i-1]), 64'd3);
      end
    end
    check("ct_both_ready", 64'(both_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
